lenet_hw_mul_pipe: RTL and testbench
====================================

Name: lenet_hw_mul_pipe

Overview:
Parametrised, pipelined successor to the single-cycle combinational HLS multiplier used in the Lenet datapath.
- Accepts one operand pair per cycle under a valid/ready handshake.
- Supports per-operand signed or unsigned interpretation.
- Applies an optional fixed-point right-shift with round-half-up and saturation.
- Delivers the result exactly NUM_STAGE accepted-cycles later.
- Sits between the conv/FC MAC operand fetch and the accumulator, which may back-pressure it.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline depth in cycles, legal range 1..8.
- DIN0_WIDTH, 49, width of operand 0.
- DIN1_WIDTH, 44, width of operand 1.
- DOUT_WIDTH, 93, result width.
- SIGNED0, 0, 1 = din0 is two's complement.
- SIGNED1, 0, 1 = din1 is two's complement.
- SHIFT, 0, arithmetic right-shift applied to the full product, range 0..DIN0_WIDTH+DIN1_WIDTH-1.
- ROUND, 0, 1 = add 2^(SHIFT-1) before shifting; ignored when SHIFT=0.
- SAT, 0, 1 = clamp to the DOUT range; 0 = keep the low DOUT_WIDTH bits.

Ports:
- ap_clk, in, 1, clock.
- ap_rst_n, in, 1, reset; asynchronous assert, active-low.
- ce, in, 1, global clock enable; when 0 the whole block holds.
- in_vld, in, 1, operand pair valid.
- in_rdy, out, 1, block can accept this cycle.
- din0, in, DIN0_WIDTH, operand 0.
- din1, in, DIN1_WIDTH, operand 1.
- out_vld, out, 1, dout valid.
- out_rdy, in, 1, consumer accepts dout.
- dout, out, DOUT_WIDTH, result.
- ovf, out, 1, qualified by out_vld; the result was saturated (SAT=1) or truncated with information loss (SAT=0).
- busy, out, 1, OR of all stage valid bits.

Behaviour:
- Reset (ap_rst_n=0, any cycle): all stage valid bits clear; out_vld=0, ovf=0, busy=0, dout=0. Data registers need not reset. An operation in flight during reset is discarded; there is no partial output after release.
- Advance: adv = ce & (~out_vld | out_rdy), where out_vld is the valid bit of the final stage.
  - in_rdy = adv. It depends combinationally on ce and out_rdy; it does not depend on in_vld.
- Accept: an operand pair is accepted when in_vld & in_rdy. On adv, stage 1 valid <= in_vld, and each stage k loads stage k-1 (data and valid).
- When adv=0, every stage holds and dout/out_vld stay stable. Bubbles are not collapsed.
- Latency: NUM_STAGE adv-cycles from acceptance to out_vld. Throughput is one result per cycle while out_rdy=1 and ce=1.
- Arithmetic:
  - Extend each operand to width+1 bits: sign-extend if SIGNEDx, otherwise zero-extend.
  - Form the exact signed product, PW = DIN0_WIDTH+DIN1_WIDTH+2 bits.
  - If ROUND and SHIFT>0, add 2^(SHIFT-1). Then shift right arithmetically by SHIFT.
  - Output range: signed if SIGNED0|SIGNED1, otherwise unsigned.
  - SAT=1: clamp to [min,max] of DOUT_WIDTH in that range and set ovf when clamped.
  - SAT=0: take the low DOUT_WIDTH bits and set ovf when the discarded high bits are not a pure sign/zero extension.
- Placement: operands are registered in stage 1, the product is formed after stage 1, and round/shift/saturate happens before the final register.
  - With NUM_STAGE=1 all of it is combinational between the stage-1 input and the output register.
  - Extra stages are plain retiming registers.
- Simultaneous in_vld with a stalled output: in_rdy=0 and nothing is accepted. The upstream must hold din0/din1/in_vld.
- ce=0 while out_rdy=1: no transfer and no advance. out_vld stays asserted if it was set; the consumer must qualify its transfer with the handshake.

Decomposition:
- Package lenet_hw_mul_pkg holds:
  - the function computing product width PW;
  - functions returning DOUT signed/unsigned min/max as PW-bit constants;
  - the parameter-legality constants NUM_STAGE_MAX=8 and SHIFT_MAX.
- Sub-module lenet_hw_mul_round_sat: combinational PW-bit product in; dout and ovf out; parametrised by SHIFT, ROUND, SAT, DOUT_WIDTH, is_signed.
- Top level: valid shift register, stall logic, data pipeline.

Test Plan:
- Defaults, unsigned, out_rdy=1: din0=2^49-1, din1=2^44-1 -> after 3 cycles dout=(2^49-1)(2^44-1), ovf=0.
- SIGNED0=SIGNED1=1, widths 8/8/16: din0=0xFD (-3), din1=0x05 -> dout=0xFFF1 (-15). Ten back-to-back pairs -> ten results on consecutive cycles.
- Back-pressure: out_rdy=0 for 5 cycles with continuous in_vld -> in_rdy=0, dout held stable, no loss or duplication; results in order after release.
- Widths 8/8/8, SIGNED 1/1, SHIFT=4, ROUND=1, SAT=1:
  - 0x7F*0x7F=16129 -> dout=0x7F, ovf=1.
  - 0x03*0x0B=33 -> (33+8)>>4 = 2, ovf=0.
- Reset mid-operation: ap_rst_n low asynchronously with 3 stages valid -> out_vld=0 and busy=0 immediately; after release, no stale output appears.
- ce=0 for 4 cycles mid-stream -> pipeline frozen, in_rdy=0; stream resumes with latency extended by exactly 4 cycles.

Source files
------------

// File: rtl/lenet_hw_mul_pkg.sv
// rtl/lenet_hw_mul_pkg.sv - shared width helpers, output range constants and legality limits
package lenet_hw_mul_pkg;

  localparam int NUM_STAGE_MAX = 8;
  // Range comparisons run at this width so any DOUT range fits regardless of PW
  localparam int WIDE_W = 512;

  function automatic int calc_pw(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  // Largest legal SHIFT for a given operand pair
  function automatic int shift_max(input int w0, input int w1);
    return w0 + w1 - 1;
  endfunction

  function automatic logic signed [WIDE_W-1:0] dout_max(input int dw, input bit is_signed);
    logic signed [WIDE_W-1:0] one;
    one = 1;
    return is_signed ? (one << (dw - 1)) - one : (one << dw) - one;
  endfunction

  function automatic logic signed [WIDE_W-1:0] dout_min(input int dw, input bit is_signed);
    logic signed [WIDE_W-1:0] one;
    one = 1;
    return is_signed ? -(one << (dw - 1)) : '0;
  endfunction

endpackage

// File: rtl/lenet_hw_mul_round_sat.sv
// rtl/lenet_hw_mul_round_sat.sv - combinational round, shift and saturate/truncate of the full product
module lenet_hw_mul_round_sat
  import lenet_hw_mul_pkg::*;
#(
  parameter int PW         = 95,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0,
  parameter int DOUT_WIDTH = 93,
  parameter bit IS_SIGNED  = 1'b0
) (
  input  logic signed [PW-1:0]   i_prod,
  output logic [DOUT_WIDTH-1:0]  o_dout,
  output logic                   o_ovf
);

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Round-half-up constant; the product always has headroom for this add
  localparam logic signed [PW-1:0] RND = (ROUND != 0 && SHIFT > 0) ? (PW'(1) << RSH) : '0;
  localparam logic signed [WIDE_W-1:0] MAX_V = dout_max(DOUT_WIDTH, IS_SIGNED);
  localparam logic signed [WIDE_W-1:0] MIN_V = dout_min(DOUT_WIDTH, IS_SIGNED);

  logic signed [PW-1:0]     w_rounded;
  logic signed [PW-1:0]     w_shifted;
  logic signed [WIDE_W-1:0] w_wide;
  logic                     w_over;
  logic                     w_under;

  assign w_rounded = i_prod + RND;
  assign w_shifted = w_rounded >>> SHIFT;
  assign w_wide    = WIDE_W'(w_shifted);
  assign w_over    = w_wide > MAX_V;
  assign w_under   = w_wide < MIN_V;

  // Out-of-range flags overflow in both modes; only SAT replaces the value with a bound
  always_comb begin
    o_ovf  = w_over | w_under;
    o_dout = w_wide[DOUT_WIDTH-1:0];
    if (SAT != 0 && w_over) begin
      o_dout = MAX_V[DOUT_WIDTH-1:0];
    end else if (SAT != 0 && w_under) begin
      o_dout = MIN_V[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lenet_hw_mul_pipe.sv
// rtl/lenet_hw_mul_pipe.sv - pipelined signed/unsigned multiplier with stall handshake and fixed-point output
module lenet_hw_mul_pipe
  import lenet_hw_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int DIN0_WIDTH = 49,
  parameter int DIN1_WIDTH = 44,
  parameter int DOUT_WIDTH = 93,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int PW         = calc_pw(DIN0_WIDTH, DIN1_WIDTH);
  localparam bit OUT_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);

  if (NUM_STAGE < 1 || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("lenet_hw_mul_pipe %0d: NUM_STAGE %0d out of range", ID, NUM_STAGE);
  end
  if (SHIFT < 0 || SHIFT > shift_max(DIN0_WIDTH, DIN1_WIDTH)) begin : g_bad_shift
    $error("lenet_hw_mul_pipe %0d: SHIFT %0d out of range", ID, SHIFT);
  end
  if (DOUT_WIDTH + 2 > WIDE_W || PW > WIDE_W) begin : g_bad_width
    $error("lenet_hw_mul_pipe %0d: widths exceed comparison width", ID);
  end

  logic [NUM_STAGE-1:0]     r_vld;
  logic [DOUT_WIDTH-1:0]    r_dout;
  logic                     r_ovf;
  logic                     w_adv;
  logic signed [DIN0_WIDTH:0] w_ext0;
  logic signed [DIN1_WIDTH:0] w_ext1;
  logic signed [PW-1:0]     w_prod;
  logic [DOUT_WIDTH-1:0]    w_res;
  logic                     w_ovf;

  // Whole pipe moves together: only when enabled and the output slot is free or draining
  assign w_adv  = ce & (~r_vld[NUM_STAGE-1] | out_rdy);
  assign in_rdy = w_adv;

  assign w_ext0 = {(SIGNED0 != 0) & din0[DIN0_WIDTH-1], din0};
  assign w_ext1 = {(SIGNED1 != 0) & din1[DIN1_WIDTH-1], din1};

  if (NUM_STAGE == 1) begin : g_comb
    assign w_prod = PW'(w_ext0) * PW'(w_ext1);
  end else begin : g_piped
    logic signed [DIN0_WIDTH:0] r_op0;
    logic signed [DIN1_WIDTH:0] r_op1;
    logic signed [PW-1:0]       w_p0;

    // Stage 1 captures the extended operands
    always_ff @(posedge ap_clk) begin
      if (w_adv) begin
        r_op0 <= w_ext0;
        r_op1 <= w_ext1;
      end
    end

    assign w_p0 = PW'(r_op0) * PW'(r_op1);

    if (NUM_STAGE == 2) begin : g_no_retime
      assign w_prod = w_p0;
    end else begin : g_retime
      logic signed [PW-1:0] r_pipe [NUM_STAGE-2];

      // Retiming registers carrying the product toward the output stage
      always_ff @(posedge ap_clk) begin
        if (w_adv) begin
          r_pipe[0] <= w_p0;
          for (int k = 1; k < NUM_STAGE - 2; k++) begin
            r_pipe[k] <= r_pipe[k-1];
          end
        end
      end

      assign w_prod = r_pipe[NUM_STAGE-3];
    end
  end

  lenet_hw_mul_round_sat #(
    .PW         (PW),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SAT        (SAT),
    .DOUT_WIDTH (DOUT_WIDTH),
    .IS_SIGNED  (OUT_SIGNED)
  ) u_round_sat (
    .i_prod (w_prod),
    .o_dout (w_res),
    .o_ovf  (w_ovf)
  );

  // Valid shift register plus output register; reset drops everything in flight
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld  <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (w_adv) begin
      r_vld[0] <= in_vld;
      for (int k = 1; k < NUM_STAGE; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      r_dout <= w_res;
      r_ovf  <= w_ovf;
    end
  end

  assign out_vld = r_vld[NUM_STAGE-1];
  assign busy    = |r_vld;
  assign dout    = r_dout;
  assign ovf     = r_ovf & out_vld;

endmodule

// File: tb/tb_lenet_hw_mul_pipe.sv
// tb/tb_lenet_hw_mul_pipe.sv - scoreboard bench for three lenet_hw_mul_pipe configurations sharing one handshake
module tb_lenet_hw_mul_pipe;

  logic ap_clk, ap_rst_n, ce, in_vld, out_rdy;
  logic [48:0] din0_a; logic [43:0] din1_a; logic [92:0] dout_a;
  logic [7:0]  din0_b, din1_b; logic [15:0] dout_b;
  logic [7:0]  din0_c, din1_c, dout_c;
  logic in_rdy_a, out_vld_a, ovf_a, busy_a;
  logic in_rdy_b, out_vld_b, ovf_b, busy_b;
  logic in_rdy_c, out_vld_c, ovf_c, busy_c;

  typedef struct {
    logic [92:0] d0;
    logic [15:0] d1;
    logic [7:0]  d2;
    logic        o2;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          adv_cnt = 0;
  logic        hold = 1'b0;
  logic        send_done;
  logic [92:0] h_a; logic [15:0] h_b; logic [7:0] h_c;

  lenet_hw_mul_pipe u_dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy_a),
    .din0(din0_a), .din1(din1_a), .out_vld(out_vld_a), .out_rdy(out_rdy),
    .dout(dout_a), .ovf(ovf_a), .busy(busy_a));

  lenet_hw_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .SIGNED0(1), .SIGNED1(1)) u_dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy_b),
    .din0(din0_b), .din1(din1_b), .out_vld(out_vld_b), .out_rdy(out_rdy),
    .dout(dout_b), .ovf(ovf_b), .busy(busy_b));

  lenet_hw_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .SIGNED0(1), .SIGNED1(1),
                      .SHIFT(4), .ROUND(1), .SAT(1)) u_dut_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy_c),
    .din0(din0_c), .din1(din1_c), .out_vld(out_vld_c), .out_rdy(out_rdy),
    .dout(dout_c), .ovf(ovf_c), .busy(busy_c));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [48:0] a0, input logic [43:0] b0,
                                 input logic [7:0] a1, input logic [7:0] b1,
                                 input logic [7:0] a2, input logic [7:0] b2);
    exp_t e;
    logic [127:0] wide;
    int p, r;
    wide = 128'(a0) * 128'(b0);
    e.d0 = wide[92:0];
    p = int'($signed(a1)) * int'($signed(b1));
    e.d1 = p[15:0];
    p = int'($signed(a2)) * int'($signed(b2));
    r = (p + 8) >>> 4;
    e.o2 = (r > 127) || (r < -128);
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    e.d2 = r[7:0];
    e.acc = 0;
    return e;
  endfunction

  // Monitor: expected valid from the scoreboard, push on accept, pop on transfer
  initial begin
    exp_t e;
    logic exp_vld;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        hold = 1'b0;
        continue;
      end
      exp_vld = 1'b0;
      if (q.size() > 0) exp_vld = (adv_cnt - q[0].acc) >= 3;
      check("out_vld_a", 128'(out_vld_a), 128'(exp_vld));
      check("out_vld_b", 128'(out_vld_b), 128'(exp_vld));
      check("out_vld_c", 128'(out_vld_c), 128'(exp_vld));
      check("in_rdy_a", 128'(in_rdy_a), 128'(ce & (~exp_vld | out_rdy)));
      check("in_rdy_c", 128'(in_rdy_c), 128'(ce & (~exp_vld | out_rdy)));
      check("busy_a", 128'(busy_a), 128'(q.size() > 0));
      if (hold) begin
        check("hold_a", 128'(dout_a), 128'(h_a));
        check("hold_b", 128'(dout_b), 128'(h_b));
        check("hold_c", 128'(dout_c), 128'(h_c));
      end
      if (out_vld_a && out_rdy && ce) begin
        if (q.size() == 0) begin
          check("spurious_out", 128'(1), 128'(0));
        end else begin
          e = q.pop_front();
          check("dout_a", 128'(dout_a), 128'(e.d0));
          check("ovf_a", 128'(ovf_a), 128'(0));
          check("dout_b", 128'(dout_b), 128'(e.d1));
          check("ovf_b", 128'(ovf_b), 128'(0));
          check("dout_c", 128'(dout_c), 128'(e.d2));
          check("ovf_c", 128'(ovf_c), 128'(e.o2));
          check("latency", 128'(adv_cnt - e.acc), 128'(3));
        end
      end
      if (in_vld && in_rdy_a) begin
        e = model(din0_a, din1_a, din0_b, din1_b, din0_c, din1_c);
        e.acc = adv_cnt;
        q.push_back(e);
      end
      hold = out_vld_a && !(out_rdy && ce);
      h_a = dout_a; h_b = dout_b; h_c = dout_c;
      if (ce && (!out_vld_a || out_rdy)) adv_cnt++;
    end
  end

  task automatic send(input logic [48:0] a0, input logic [43:0] b0, input logic [7:0] a1,
                      input logic [7:0] b1, input logic [7:0] a2, input logic [7:0] b2);
    in_vld = 1'b1;
    din0_a = a0; din1_a = b0; din0_b = a1; din1_b = b1; din0_c = a2; din1_c = b2;
    for (int t = 0; t < 100; t++) begin
      @(negedge ap_clk);
      if (in_rdy_a) begin
        @(posedge ap_clk);
        #1;
        in_vld = 1'b0;
        return;
      end
    end
    check("send_timeout", 128'(0), 128'(1));
    in_vld = 1'b0;
  endtask

  task automatic send_rand();
    send(49'({$urandom(), $urandom()}), 44'({$urandom(), $urandom()}), 8'($urandom()),
         8'($urandom()), 8'($urandom()), 8'($urandom()));
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge ap_clk);
    #1;
    check("drain", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0; ce = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    din0_a = '0; din1_a = '0; din0_b = '0; din1_b = '0; din0_c = '0; din1_c = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_vld", 128'(out_vld_a), 128'(0));
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_dout", 128'(dout_a), 128'(0));
    check("rst_ovf", 128'(ovf_c), 128'(0));
    ap_rst_n = 1'b1;

    send('1, '1, 8'hFD, 8'h05, 8'h7F, 8'h7F);
    send(49'd12345, 44'd678, 8'h80, 8'h80, 8'h03, 8'h0B);
    send(49'd1, '1, 8'h7F, 8'h81, 8'h7F, 8'h81);
    send('1, 44'd0, 8'h80, 8'h7F, 8'hFE, 8'h05);
    send(49'd2, 44'd3, 8'h01, 8'hFF, 8'h08, 8'h01);
    send(49'h1_0000_0000_0000, 44'h800_0000_0000, 8'h00, 8'h55, 8'h07, 8'h01);
    drain();

    repeat (10) send_rand();
    drain();

    fork
      begin
        repeat (12) send_rand();
      end
      begin
        repeat (4) @(posedge ap_clk);
        #1;
        out_rdy = 1'b0;
        repeat (5) begin
          @(negedge ap_clk);
          check("bp_in_rdy", 128'(in_rdy_a), 128'(0));
        end
        @(posedge ap_clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    drain();

    fork
      begin
        repeat (10) send_rand();
      end
      begin
        repeat (4) @(posedge ap_clk);
        #1;
        ce = 1'b0;
        repeat (4) begin
          @(negedge ap_clk);
          check("ce_in_rdy", 128'(in_rdy_a), 128'(0));
        end
        @(posedge ap_clk);
        #1;
        ce = 1'b1;
      end
    join
    drain();

    repeat (3) send_rand();
    check("pre_rst_vld", 128'(out_vld_a), 128'(1));
    check("pre_rst_busy", 128'(busy_a), 128'(1));
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 128'(out_vld_a), 128'(0));
    check("mid_rst_busy", 128'(busy_a), 128'(0));
    check("mid_rst_busy_c", 128'(busy_c), 128'(0));
    q.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    repeat (8) @(posedge ap_clk);
    #1;
    check("post_rst_vld", 128'(out_vld_a), 128'(0));
    check("post_rst_busy", 128'(busy_a), 128'(0));

    send_done = 1'b0;
    fork
      begin
        repeat (30) send_rand();
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          @(posedge ap_clk);
          #1;
          out_rdy = 1'($urandom_range(0, 1));
          ce = ($urandom_range(0, 7) != 0);
        end
      end
    join
    out_rdy = 1'b1;
    ce = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
